// File: rtl/msdf_otf_converter.sv
`default_nettype none
// ============================================================================
// Module   : msdf_otf_converter
// Brief    : Sink of the MSDF signed-digit result stream. It converts one
//            N-digit borrow-save word into an (N+1)-bit two's-complement
//            integer as the digits arrive, using the Q/QM on-the-fly
//            registers, so no final carry-propagate add is needed.
//            A start pulse frames each word and a one-cycle done pulse marks
//            its completion.
// Options  : `define MSDF_DIGIT_ERR_EN to enable the sticky illegal-digit flag
//            (p=1,n=1). When the macro is undefined, digit_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module msdf_otf_converter #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         digit_valid,
    input  logic         digit_p,
    input  logic         digit_n,
    output logic         busy,
    output logic         done,
    output logic [N:0]   result,
    output logic         digit_err
);

    localparam int             CW         = $clog2(N + 1);
    localparam logic [CW-1:0]  c_last_cnt = CW'(N - 1);
    localparam logic [CW-1:0]  c_cnt_one  = CW'(1);
    localparam logic [N:0]     c_one      = (N+1)'(1);
    localparam logic [N:0]     c_minus1   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;
    logic [N:0]      r_q;
    logic [N:0]      r_qm;
    logic [N:0]      r_result;
    logic [N:0]      w_q_next;
    logic [N:0]      w_qm_next;
    logic            w_plus;
    logic            w_minus;
    logic            w_accept;
    logic            w_last;

    // Rail decode: p=n (either 0,0 or 1,1) is a zero digit.
    assign w_plus   = digit_p & ~digit_n;
    assign w_minus  = ~digit_p & digit_n;

    // A digit is absorbed only while framing a word; a coincident start
    // takes priority and discards the digit.
    assign w_accept = (r_state == ACTIVE) & digit_valid & ~start;
    assign w_last   = w_accept & (r_count == c_last_cnt);

    assign busy     = (r_state == ACTIVE);
    assign done     = (r_state == DONE);
    assign result   = r_result;

    // On-the-fly conversion step; QM = Q - 1 is preserved by every branch.
    always_comb begin
        w_q_next  = r_q << 1;
        w_qm_next = (r_qm << 1) | c_one;
        if (w_plus) begin
            w_q_next  = (r_q << 1) | c_one;
            w_qm_next = r_q << 1;
        end else if (w_minus) begin
            w_q_next  = (r_qm << 1) | c_one;
            w_qm_next = r_qm << 1;
        end
    end

    // Next-state logic: start always (re)enters ACTIVE, DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (start) begin
                    w_state_next = ACTIVE;
                end else if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_next = ACTIVE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Conversion registers, digit counter and completed-word result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            r_qm     <= c_minus1;
            r_count  <= '0;
            r_result <= '0;
        end else if (start) begin
            r_q      <= '0;
            r_qm     <= c_minus1;
            r_count  <= '0;
        end else if (w_accept) begin
            r_q      <= w_q_next;
            r_qm     <= w_qm_next;
            r_count  <= r_count + c_cnt_one;
            if (w_last) begin
                r_result <= w_q_next;
            end
        end
    end

`ifdef MSDF_DIGIT_ERR_EN
    logic r_digit_err;

    // Sticky flag for an accepted digit with both rails high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit_err <= 1'b0;
        end else if (start) begin
            r_digit_err <= 1'b0;
        end else if (w_accept & digit_p & digit_n) begin
            r_digit_err <= 1'b1;
        end
    end

    assign digit_err = r_digit_err;
`else
    assign digit_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msdf_otf_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_msdf_otf_converter
// Brief    : Self-checking bench for msdf_otf_converter (N=9). Expected words
//            are computed from the driven digits and queued; the done monitor
//            pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msdf_otf_converter;

    localparam int N = 9;
`ifdef MSDF_DIGIT_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         digit_valid = 1'b0;
    logic         digit_p = 1'b0;
    logic         digit_n = 1'b0;
    logic         busy;
    logic         done;
    logic [N:0]   result;
    logic         digit_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    logic [N:0]   exp_q[$];

    msdf_otf_converter #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .digit_valid (digit_valid),
        .digit_p     (digit_p),
        .digit_n     (digit_n),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .digit_err   (digit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done pulse must match a queued expected word.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            chk("done_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("result_word", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared_by_start", 32'(digit_err), 32'd0);
    endtask

    // d: +1, -1, 0, or 2 meaning p=1,n=1. Gap cycles keep rails toggled
    // with valid low, which must be ignored.
    task automatic send(input int d, input int gap);
        digit_valid = 1'b1;
        digit_p     = (d == 1) || (d == 2);
        digit_n     = (d == -1) || (d == 2);
        tick();
        digit_valid = 1'b0;
        digit_p     = 1'b1;
        digit_n     = 1'b0;
        repeat (gap) tick();
        digit_p     = 1'b0;
    endtask

    // Full word from start: model value is the plain weighted digit sum.
    task automatic run_word(input string tag, input int d[9], input int gap[9]);
        int acc;
        acc = 0;
        do_start();
        for (int i = 0; i < N; i++) begin
            acc = acc * 2 + ((d[i] == 2) ? 0 : d[i]);
            if (i == N - 1) exp_q.push_back(acc[N:0]);
            send(d[i], gap[i]);
            if (d[i] == 2) chk({tag, "_err_flag"}, 32'(digit_err), 32'(ERR_EN));
            if (i < N - 1) chk({tag, "_no_early_done"}, 32'(done), 32'd0);
        end
        chk({tag, "_done_latency"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int z[9];
        int g0[9];
        int gd;
        z  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        g0 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(digit_err), 32'd0);
        tick();

        // Digits in IDLE are ignored.
        digit_valid = 1'b1; digit_p = 1'b1;
        repeat (3) tick();
        digit_valid = 1'b0; digit_p = 1'b0;
        chk("idle_ignores_digits", 32'(busy), 32'd0);

        run_word("all_plus",  '{1, 1, 1, 1, 1, 1, 1, 1, 1}, g0);
        chk("all_plus_result_hold", 32'(result), 32'h1FF);
        run_word("all_minus", '{-1, -1, -1, -1, -1, -1, -1, -1, -1}, g0);
        chk("all_minus_result_hold", 32'(result), 32'h201);
        run_word("gapped", '{-1, 1, 1, 1, 1, 1, 1, 1, 1}, '{0, 0, 2, 0, 0, 2, 0, 0, 0});
        run_word("w128", '{1, -1, 0, 0, 0, 0, 0, 0, 0}, g0);
        chk("w128_result_hold", 32'(result), 32'd128);

        // Start with a coincident digit: the digit must be dropped.
        start = 1'b1; digit_valid = 1'b1; digit_p = 1'b1;
        tick();
        start = 1'b0; digit_valid = 1'b0; digit_p = 1'b0;
        exp_q.push_back('0);
        for (int i = 0; i < N; i++) send(0, 0);
        chk("coincident_done", 32'(done), 32'd1);
        tick();

        // Abort after 5 digits, then a clean all-plus word.
        gd = n_done;
        do_start();
        for (int i = 0; i < 5; i++) send(-1, 0);
        chk("abort_result_kept", 32'(result), 32'd0);
        run_word("after_abort", '{1, 1, 1, 1, 1, 1, 1, 1, 1}, g0);
        chk("abort_single_done", 32'(n_done - gd), 32'd1);

        // Start during DONE: done still pulses, new word proceeds.
        do_start();
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) exp_q.push_back(10'h201);
            send(-1, 0);
        end
        start = 1'b1; digit_valid = 1'b1; digit_n = 1'b1;
        chk("start_in_done_pulse", 32'(done), 32'd1);
        tick();
        start = 1'b0; digit_valid = 1'b0; digit_n = 1'b0;
        chk("start_in_done_busy", 32'(busy), 32'd1);
        exp_q.push_back(10'd3);
        for (int i = 0; i < N; i++) send((i >= 7) ? 1 : 0, 0);
        chk("start_in_done_word2", 32'(done), 32'd1);
        tick();

        // Illegal digit at position 3.
        run_word("err_word", '{1, 1, 2, 1, 1, 1, 1, 1, 1}, g0);
        chk("err_sticky", 32'(digit_err), 32'(ERR_EN));
        chk("err_result", 32'(result), 32'd447);
        run_word("after_err", z, g0);

        // Reset mid-word.
        gd = n_done;
        do_start();
        for (int i = 0; i < 4; i++) send(1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (12) tick();
        chk("midrst_no_done", 32'(n_done - gd), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
